// File: rtl/des_key_sched.sv
// Sequential DES/3DES key schedule: PC-1 per key, per-round C/D rotation, PC-2, one subkey per beat.
// Optional key parity checker enabled by defining DES_KEY_PARITY_CHK_EN.
module des_key_sched #(
    parameter int unsigned N_KEYS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode_dec,
    input  logic [64*N_KEYS-1:0]  key_in,
    output logic                  ready,
    output logic                  sk_valid,
    input  logic                  sk_ready,
    output logic [47:0]           sk_data,
    output logic [3:0]            sk_round,
    output logic [1:0]            sk_pass,
    output logic                  sk_last,
    output logic                  parity_err
);

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam logic [1:0] LAST_PASS = 2'(N_KEYS - 1);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++) r[55-i] = k[64-PC1_TBL[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TBL[i]];
        return r;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic two);
        if (right) return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [55:0] step_cd(input logic [55:0] cd, input logic right, input logic two);
        return {rot28(cd[55:28], right, two), rot28(cd[27:0], right, two)};
    endfunction

    // SHIFT[idx] is 1 at idx 1, 2, 9, 16 and 2 elsewhere
    function automatic logic shift_two(input logic [4:0] idx);
        return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
    endfunction

    // Key slot used by pass p; in decrypt order the keys run backwards and key3 aliases key1 when N_KEYS=2
    function automatic logic [1:0] key_idx(input logic [1:0] p, input logic dec_order);
        if (!dec_order) return p;
        if (N_KEYS == 1) return 2'd0;
        if (N_KEYS == 2 && p == 2'd0) return 2'd0;
        return 2'd2 - p;
    endfunction

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [63:0] keys_q [3];
    logic [63:0] keys_d [3];
    logic [55:0] cd_q, cd_d;
    logic [47:0] sk_data_q, sk_data_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  pass_q, pass_d;
    logic        last_q, last_d;
    logic [55:0] cd0;
    logic [1:0]  pass_n;
    logic        pdec;
    logic [4:0]  sh_idx;

    // The LOAD step is folded into the acceptance cycle so the first subkey is registered at T+1
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        keys_d    = keys_q;
        cd_d      = cd_q;
        sk_data_d = sk_data_q;
        round_d   = round_q;
        pass_d    = pass_q;
        last_d    = last_q;
        cd0       = '0;
        pass_n    = '0;
        pdec      = 1'b0;
        sh_idx    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode_dec;
                    for (int unsigned i = 0; i < N_KEYS; i++) keys_d[i] = key_in[64*i +: 64];
                    pdec      = mode_dec;
                    cd0       = pc1(keys_d[key_idx(2'd0, mode_dec)]);
                    cd_d      = pdec ? cd0 : step_cd(cd0, 1'b0, 1'b0);
                    sk_data_d = pc2(cd_d);
                    round_d   = '0;
                    pass_d    = '0;
                    last_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (sk_ready) begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        last_d  = 1'b0;
                    end else begin
                        if (round_q == 4'd15) begin
                            pass_n  = pass_q + 2'd1;
                            pdec    = mode_q ^ (pass_n == 2'd1);
                            cd0     = pc1(keys_q[key_idx(pass_n, mode_q)]);
                            cd_d    = pdec ? cd0 : step_cd(cd0, 1'b0, 1'b0);
                            round_d = '0;
                            pass_d  = pass_n;
                        end else begin
                            pdec    = mode_q ^ (pass_q == 2'd1);
                            sh_idx  = pdec ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
                            cd_d    = step_cd(cd_q, pdec, shift_two(sh_idx));
                            round_d = round_q + 4'd1;
                        end
                        sk_data_d = pc2(cd_d);
                        last_d    = (pass_d == LAST_PASS) && (round_d == 4'd15);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            keys_q    <= '{default: '0};
            cd_q      <= '0;
            sk_data_q <= '0;
            round_q   <= '0;
            pass_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            keys_q    <= keys_d;
            cd_q      <= cd_d;
            sk_data_q <= sk_data_d;
            round_q   <= round_d;
            pass_q    <= pass_d;
            last_q    <= last_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign sk_valid = (state_q == ST_RUN);
    assign sk_data  = sk_data_q;
    assign sk_round = round_q;
    assign sk_pass  = pass_q;
    assign sk_last  = last_q;

`ifdef DES_KEY_PARITY_CHK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (state_q == ST_IDLE && start) begin
            perr_d = 1'b0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (!(^key_in[64*i + 8*b +: 8])) perr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: a DES instance (N_KEYS=1) and a 3DES instance (N_KEYS=3).
module tb_des_key_sched;

    localparam logic [63:0] KEY_A    = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_ZERO = 64'h0101010101010101;
    localparam logic [63:0] KEY_ONES = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] KEY_CZDO = 64'h1F1F1F1F0E0E0E0E;

    logic [47:0] ENC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start1 = 1'b0, start3 = 1'b0, mode = 1'b0, skr = 1'b1;
    logic [63:0]  key1 = '0;
    logic [191:0] key3 = '0;
    logic         o1_ready, o1_valid, o1_last, o1_perr;
    logic [47:0]  o1_data;
    logic [3:0]   o1_round;
    logic [1:0]   o1_pass;
    logic         o3_ready, o3_valid, o3_last, o3_perr;
    logic [47:0]  o3_data;
    logic [3:0]   o3_round;
    logic [1:0]   o3_pass;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [55:0] q1 [$];
    logic [55:0] q3 [$];
    bit          stall [4];
    logic [55:0] held [4];

    always #5 clk = ~clk;

    des_key_sched #(.N_KEYS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode_dec(mode), .key_in(key1),
        .ready(o1_ready), .sk_valid(o1_valid), .sk_ready(skr), .sk_data(o1_data),
        .sk_round(o1_round), .sk_pass(o1_pass), .sk_last(o1_last), .parity_err(o1_perr)
    );

    des_key_sched #(.N_KEYS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode_dec(mode), .key_in(key3),
        .ready(o3_ready), .sk_valid(o3_valid), .sk_ready(skr), .sk_data(o3_data),
        .sk_round(o3_round), .sk_pass(o3_pass), .sk_last(o3_last), .parity_err(o3_perr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // kind: 0 forward schedule of KEY_A, 1 reversed, 2 all-zero, 3 all-one, 4 C=0/D=1
    function automatic logic [47:0] exp_sk(input int kind, input int r);
        case (kind)
            0:       return ENC[r];
            1:       return ENC[15-r];
            2:       return 48'h000000000000;
            3:       return 48'hFFFFFFFFFFFF;
            default: return 48'h000000FFFFFF;
        endcase
    endfunction

    task automatic push_pass(input int inst, input int p, input int kind, input bit fin);
        logic [55:0] e;
        for (int r = 0; r < 16; r++) begin
            e = {1'b1, fin && (r == 15), 2'(p), 4'(r), exp_sk(kind, r)};
            if (inst == 1) q1.push_back(e);
            else           q3.push_back(e);
        end
    endtask

    task automatic mon(input int inst, input logic v, input logic [55:0] obs);
        logic [55:0] e;
        if (rst) begin
            stall[inst] = 1'b0;
        end else begin
            if (stall[inst]) check($sformatf("stall_hold_dut%0d", inst), 64'(obs), 64'(held[inst]));
            if (v && skr) begin
                if ((inst == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_unexpected_dut%0d: got %h expected no beat", inst, obs);
                end else begin
                    e = (inst == 1) ? q1.pop_front() : q3.pop_front();
                    check($sformatf("beat_dut%0d", inst), 64'(obs), 64'(e));
                end
            end
            stall[inst] = v && !skr;
            held[inst]  = obs;
        end
    endtask

    always @(negedge clk) begin
        mon(1, o1_valid, {o1_valid, o1_last, o1_pass, o1_round, o1_data});
        mon(3, o3_valid, {o3_valid, o3_last, o3_pass, o3_round, o3_data});
    end

    task automatic kick(input int inst, input bit dec);
        mode = dec;
        if (inst == 1) start1 = 1'b1;
        else           start3 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = ~dec;
        key1   = ~key1;
        key3   = ~key3;
    endtask

    task automatic wait_done(input int inst, input bit rnd, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            skr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            done = (inst == 1) ? (q1.size() == 0 && o1_ready) : (q3.size() == 0 && o3_ready);
            @(posedge clk); #1;
            n++;
        end
        skr = 1'b1;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL done_dut%0d: got timeout after %0d cycles expected completion", inst, budget);
        end
    endtask

    initial begin
        #200000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_dut1", 64'(o1_ready), 64'd1);
        check("rst_out_dut1", 64'({o1_valid, o1_last, o1_pass, o1_round, o1_data, o1_perr}), 64'd0);
        check("rst_ready_dut3", 64'(o3_ready), 64'd1);
        check("rst_out_dut3", 64'({o3_valid, o3_last, o3_pass, o3_round, o3_data, o3_perr}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // DES encrypt with timing checks
        key1 = KEY_A;
        push_pass(1, 0, 0, 1'b1);
        kick(1, 1'b0);
        @(negedge clk);
        check("first_valid_T1", 64'({o1_valid, o1_ready}), 64'b10);
        check("parity_keyA", 64'(o1_perr), 64'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("last_beat_flags", 64'({o1_last, o1_ready, o1_valid}), 64'b101);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_last", 64'({o1_ready, o1_valid}), 64'b10);
        @(posedge clk); #1;
        wait_done(1, 1'b0, 50);

        // DES decrypt: reversed stream; inputs scrambled after acceptance
        key1 = KEY_A;
        push_pass(1, 0, 1, 1'b1);
        kick(1, 1'b1);
        wait_done(1, 1'b0, 50);

        // DES encrypt under random backpressure
        key1 = KEY_A;
        push_pass(1, 0, 0, 1'b1);
        kick(1, 1'b0);
        wait_done(1, 1'b1, 300);

        // 3DES encrypt: enc(K1=zero), dec(K2=A), enc(K3=ones), no gaps, start while busy ignored
        key3 = {KEY_ONES, KEY_A, KEY_ZERO};
        push_pass(3, 0, 2, 1'b0);
        push_pass(3, 1, 1, 1'b0);
        push_pass(3, 2, 3, 1'b1);
        kick(3, 1'b0);
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (o3_valid) cnt++;
            start3 = (i == 20);
        end
        start3 = 1'b0;
        check("no_gap_3des", 64'(cnt), 64'd48);
        @(posedge clk); #1;
        wait_done(3, 1'b0, 50);

        // 3DES decrypt: dec(K3), enc(K2), dec(K1), with backpressure
        key3 = {KEY_ONES, KEY_A, KEY_ZERO};
        push_pass(3, 0, 3, 1'b0);
        push_pass(3, 1, 0, 1'b0);
        push_pass(3, 2, 2, 1'b1);
        kick(3, 1'b1);
        wait_done(3, 1'b1, 600);

        // Reset mid-schedule, start coincident with rst is dropped, then a fresh schedule
        key1 = KEY_A;
        push_pass(1, 0, 0, 1'b1);
        kick(1, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst    = 1'b1;
        start1 = 1'b1;
        key1   = KEY_CZDO;
        mode   = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        start1 = 1'b0;
        q1.delete();
        @(negedge clk);
        check("midrst_ready", 64'(o1_ready), 64'd1);
        check("midrst_out", 64'({o1_valid, o1_last, o1_pass, o1_round, o1_data, o1_perr}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("start_with_rst_dropped", 64'(o1_valid), 64'd0);
        @(posedge clk); #1;
        key1 = KEY_CZDO;
        push_pass(1, 0, 4, 1'b1);
        kick(1, 1'b0);
        wait_done(1, 1'b0, 50);

`ifdef DES_KEY_PARITY_CHK_EN
        key1 = 64'h0;
        push_pass(1, 0, 2, 1'b1);
        kick(1, 1'b0);
        @(negedge clk);
        check("parity_even_key", 64'(o1_perr), 64'd1);
        @(posedge clk); #1;
        wait_done(1, 1'b0, 50);
        key1 = KEY_ZERO;
        push_pass(1, 0, 2, 1'b1);
        kick(1, 1'b0);
        @(negedge clk);
        check("parity_odd_key", 64'(o1_perr), 64'd0);
        @(posedge clk); #1;
        wait_done(1, 1'b0, 50);
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
